fxp_mac_pipe: RTL and testbench

- Parametrised, pipelined signed fixed-point multiply-accumulate engine for the MMM datapath.
- Successor to the combinational 16-bit Q2.14 multiplier: width and fraction point are generic, the multiply is pipelined, and products are accumulated over a dot-product run.
- Adds selectable rounding and saturation, and a valid/ready handshake on input and output.
- Sits between the operand-fetch FIFOs and the result write-back in each processing element.

---
 rtl/fxp_mac_pipe.sv | 136 +++++++++++++
 tb/tb_fxp_mac_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fxp_mac_pipe.sv
// Pipelined signed fixed-point multiply-accumulate with per-element rounding/saturation
// sideband and a single global-enable valid/ready handshake on both ports.
module fxp_mac_pipe #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 14,
  parameter int GUARD = 8,
  parameter int PIPE  = 2
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_a,
  input  logic signed [WIDTH-1:0] in_b,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic                    cfg_round,
  input  logic                    cfg_sat,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_ovf
);

  localparam int PW = 2 * WIDTH;
  localparam int AW = PW + GUARD;
  // One extra bit so the rounding increment can never wrap the accumulator value.
  localparam int TW = AW + 1;

  localparam logic signed [TW-1:0] RND_C  = {{(TW-1){1'b0}}, 1'b1} << (FRAC - 1);
  localparam logic signed [TW-1:0] ZERO_C = '0;
  localparam logic signed [TW-1:0] MAX_C  = {{(TW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [TW-1:0] MIN_C  = {{(TW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef struct packed {
    logic          vld;
    logic          first;
    logic          last;
    logic          rnd;
    logic          sat;
    logic [PW-1:0] prod;
  } stage_t;

  stage_t stage_q [PIPE];
  stage_t stage_d [PIPE];
  stage_t tail;

  logic signed [PW-1:0] mult;
  logic signed [AW-1:0] acc_q, acc_d, acc_sum, prod_ext;
  logic signed [TW-1:0] acc_ext, rnd_add, sum_rnd, t_val;
  logic                 en, fire, t_ovf;
  logic [WIDTH-1:0]     t_data;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_ovf_q, out_ovf_d;

  // A stalled output freezes the whole pipe, so one enable serves every stage.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;
  assign mult     = PW'(in_a) * PW'(in_b);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    stage_d = stage_q;
    if (en) begin
      stage_d[0].vld   = in_valid;
      stage_d[0].first = in_first;
      stage_d[0].last  = in_last;
      stage_d[0].rnd   = cfg_round;
      stage_d[0].sat   = cfg_sat;
      stage_d[0].prod  = mult;
      for (int i = 1; i < PIPE; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_comb begin
    tail     = stage_q[PIPE-1];
    fire     = en && tail.vld;
    prod_ext = AW'($signed(tail.prod));
    acc_sum  = tail.first ? prod_ext : acc_q + prod_ext;
    acc_d    = fire ? acc_sum : acc_q;

    acc_ext  = {acc_sum[AW-1], acc_sum};
    rnd_add  = tail.rnd ? RND_C : ZERO_C;
    sum_rnd  = acc_ext + rnd_add;
    t_val    = sum_rnd >>> FRAC;
    t_ovf    = (t_val > MAX_C) || (t_val < MIN_C);
    if (tail.sat && t_ovf) begin
      t_data = t_val[TW-1] ? MIN_C[WIDTH-1:0] : MAX_C[WIDTH-1:0];
    end else begin
      t_data = t_val[WIDTH-1:0];
    end
  end

  // Whenever enabled the output slot is empty or being drained, so it simply takes
  // whatever the accumulate stage produces this cycle.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    if (en) begin
      out_valid_d = fire && tail.last;
      if (fire && tail.last) begin
        out_data_d = t_data;
        out_ovf_d  = t_ovf;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < PIPE; i++) begin
        stage_q[i] <= '0;
      end
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      stage_q     <= stage_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_fxp_mac_pipe.sv
// Scoreboard bench for fxp_mac_pipe: directed plan vectors plus randomized runs
// with backpressure, checked against an integer-arithmetic reference model.
module tb_fxp_mac_pipe;

  localparam int WIDTH = 16;
  localparam int FRAC  = 14;
  localparam int GUARD = 8;
  localparam int PIPE  = 2;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic        cfg_round = 1'b0;
  logic        cfg_sat = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_ovf;

  fxp_mac_pipe #(.WIDTH(WIDTH), .FRAC(FRAC), .GUARD(GUARD), .PIPE(PIPE)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_first(in_first), .in_last(in_last), .cfg_round(cfg_round), .cfg_sat(cfg_sat),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] d;
    logic        o;
    string       tag;
  } exp_t;

  exp_t   sb[$];
  longint macc = 0;
  bit     bp_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: exact integer product/sum, 40-bit accumulator wrap, floor shift.
  function automatic void ref_out(input longint acc, input bit r, input bit s,
                                  output logic [15:0] d, output logic o);
    longint t;
    t = (acc + (r ? 64'sd8192 : 64'sd0)) >>> FRAC;
    o = (t > 64'sd32767) || (t < -64'sd32768);
    if (s && o) d = (t < 0) ? 16'h8000 : 16'h7FFF;
    else        d = t[15:0];
  endfunction

  task automatic accept(input logic [15:0] a, input logic [15:0] b, input bit f, input bit l,
                        input bit r, input bit s, input bit use_dir,
                        input logic [15:0] ed, input logic eo, input string tag);
    longint      p;
    exp_t        e;
    logic [15:0] md;
    logic        mo;
    p    = longint'($signed(a)) * longint'($signed(b));
    macc = f ? p : macc + p;
    macc = (macc <<< 24) >>> 24;
    if (l) begin
      ref_out(macc, r, s, md, mo);
      e.d   = use_dir ? ed : md;
      e.o   = use_dir ? eo : mo;
      e.tag = tag;
      sb.push_back(e);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input bit f, input bit l,
                      input bit r, input bit s, input bit use_dir,
                      input logic [15:0] ed, input logic eo, input string tag);
    bit done = 1'b0;
    in_a = a; in_b = b; in_first = f; in_last = l; cfg_round = r; cfg_sat = s;
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (in_ready) begin
        accept(a, b, f, l, r, s, use_dir, ed, eo, tag);
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_accept_timeout: got in_ready=0 expected 1", tag);
    end
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run1(input logic [15:0] a, input logic [15:0] b, input bit r, input bit s,
                      input logic [15:0] ed, input logic eo, input string tag);
    send(a, b, 1'b1, 1'b1, r, s, 1'b1, ed, eo, tag);
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 300 && (sb.size() != 0 || out_valid); k++) @(posedge CLK);
    #1;
    check({tag, "_pending"}, sb.size(), 0);
  endtask

  always @(posedge CLK) begin
    #1;
    out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: a result is consumed at the next edge when out_valid && out_ready here.
  always @(negedge CLK) begin
    exp_t e;
    if (RST_N) begin
      check("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got 0x%0h expected none", out_data);
        end else begin
          e = sb.pop_front();
          check({e.tag, "_data"}, out_data, e.d);
          check({e.tag, "_ovf"}, out_ovf, e.o);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: got no finish expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int lat;
    bit nf;
    int len;

    repeat (3) @(posedge CLK);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ovf", out_ovf, 0);
    #2 RST_N = 1'b1;
    #1 check("rst_in_ready", in_ready, 1);
    @(posedge CLK);
    #1;

    // Legacy single-element behaviour and latency.
    run1(16'h4000, 16'h4000, 0, 0, 16'h4000, 0, "legacy_pos");
    lat = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (out_valid) break;
      lat++;
    end
    check("latency", lat, PIPE + 1);
    @(posedge CLK);
    #1;
    run1(16'hC000, 16'h4000, 0, 0, 16'hC000, 0, "legacy_neg");

    // Overflow, saturate vs wrap.
    run1(16'h7FFF, 16'h7FFF, 0, 1, 16'h7FFF, 1, "ovf_sat");
    run1(16'h7FFF, 16'h7FFF, 0, 0, 16'hFFFC, 1, "ovf_wrap");
    run1(16'h8000, 16'h8000, 0, 1, 16'h7FFF, 1, "ovf_minmin");

    // Rounding at the half-LSB point, both signs.
    run1(16'h0001, 16'h2000, 0, 0, 16'h0000, 0, "rnd_trunc_pos");
    run1(16'h0001, 16'h2000, 1, 0, 16'h0001, 0, "rnd_round_pos");
    run1(16'hFFFF, 16'h2000, 1, 0, 16'h0000, 0, "rnd_round_neg");
    run1(16'hFFFF, 16'h2000, 0, 0, 16'hFFFF, 0, "rnd_trunc_neg");

    // Accumulation runs.
    send(16'h1000, 16'h4000, 1, 0, 0, 0, 0, 0, 0, "acc3");
    send(16'h1000, 16'h4000, 0, 0, 0, 0, 0, 0, 0, "acc3");
    send(16'h1000, 16'h4000, 0, 1, 0, 0, 1, 16'h3000, 0, "acc3");
    send(16'h2000, 16'h4000, 1, 0, 0, 1, 0, 0, 0, "acc4sat");
    for (int i = 0; i < 2; i++) send(16'h2000, 16'h4000, 0, 0, 0, 1, 0, 0, 0, "acc4sat");
    send(16'h2000, 16'h4000, 0, 1, 0, 1, 1, 16'h7FFF, 1, "acc4sat");
    run1(16'h4000, 16'h4000, 0, 0, 16'h4000, 0, "acc_fresh");
    wait_drain("directed");
    @(posedge CLK);
    #1;

    // Reset in the middle of a 4-element run.
    send(16'h1000, 16'h4000, 1, 0, 0, 0, 0, 0, 0, "mid");
    send(16'h1000, 16'h4000, 0, 0, 0, 0, 0, 0, 0, "mid");
    #2 RST_N = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_ovf", out_ovf, 0);
    macc = 0;
    #7 RST_N = 1'b1;
    @(posedge CLK);
    #1;
    send(16'h4000, 16'h4000, 0, 1, 0, 0, 1, 16'h4000, 0, "post_reset");
    wait_drain("reset");
    @(posedge CLK);
    #1;

    // Randomized runs with bubbles and random output backpressure.
    bp_mode = 1'b1;
    for (int run = 0; run < 80; run++) begin
      len = $urandom_range(1, 4);
      nf  = ($urandom_range(0, 7) == 0);
      for (int e = 0; e < len; e++) begin
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 2)) begin
            @(posedge CLK);
            #1;
          end
        end
        send(16'($urandom), 16'($urandom), (e == 0) && !nf, e == len - 1,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, 0, "rand");
      end
    end
    bp_mode = 1'b0;
    wait_drain("random");
    check("final_out_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
